// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows byte/half/word stores into serial byte writes with alignment check
module store_narrow_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              ready_o,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              misalign_o
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        idx_q, idx_d, last_q, last_d;
  logic              aligned;
  assign aligned = (size_i == 2'd0) || (size_i == 2'd1 && !addr_i[0]) || (size_i == 2'd2 && addr_i[1:0] == 2'b00);
  // state and transfer registers; reset aborts any transfer in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
  // next state: accept/reject in IDLE, advance byte index on each handshake
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (req_i) begin
        state_d = aligned ? WRITE : ERR;
        if (aligned) begin
          addr_d = addr_i;
          data_d = data_i;
          idx_d  = 2'd0;
          last_d = size_i == 2'd0 ? 2'd0 : size_i == 2'd1 ? 2'd1 : 2'd3;
        end
      end
      WRITE: if (mem_ready_i) begin
        state_d = idx_q == last_q ? DONE : WRITE;
        idx_d   = idx_q == last_q ? idx_q : idx_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ready_o    = state_q == IDLE;
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign misalign_o = state_q == ERR;
  assign mem_we_o   = state_q == WRITE;
  assign mem_addr_o = mem_we_o ? addr_q + ADDR_W'(idx_q) : '0;
  assign mem_data_o = mem_we_o ? data_q[8*idx_q +: 8] : '0;
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: vector table, random model comparison and corner sequences
module tb_store_narrow_unit;
  logic        clk = 0, rst_n = 0, req = 0, mem_ready = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, data = 0;
  logic        ready_o, mem_we_o, busy_o, done_o, misalign_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  int checks = 0, failures = 0;
  int nx, n_done, n_mis, done_cyc, mis_cyc;
  logic [31:0] xa[8];
  logic [7:0]  xd[8];

  store_narrow_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .ready_o(ready_o), .size_i(size),
    .addr_i(addr), .data_i(data), .mem_ready_i(mem_ready), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .busy_o(busy_o),
    .done_o(done_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // mode 0: memory always ready, 1: random ready, 2: ready low for the first 3 cycles
  task automatic run(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d, input int mode);
    int guard = 0;
    bit stall = 0;
    logic [31:0] pa = 0;
    logic [7:0] pd = 0;
    nx = 0; n_done = 0; n_mis = 0; done_cyc = 0; mis_cyc = 0;
    @(negedge clk);
    while (!ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", ready_o, 1);
    req = 1; size = s; addr = a; data = d;
    @(negedge clk);
    req = 0; size = 2'($urandom); addr = $urandom; data = $urandom;
    for (int c = 1; c <= 40; c++) begin
      mem_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (c > 3);
      if (stall) begin
        chk("hold_we", mem_we_o, 1);
        chk("hold_addr", mem_addr_o, pa);
        chk("hold_data", mem_data_o, pd);
      end
      if (!mem_we_o) begin
        chk("idle_addr", mem_addr_o, 0);
        chk("idle_data", mem_data_o, 0);
      end
      if (mem_we_o && mem_ready) begin
        if (nx < 8) begin
          xa[nx] = mem_addr_o;
          xd[nx] = mem_data_o;
        end
        nx++;
      end
      stall = mem_we_o && !mem_ready;
      pa = mem_addr_o;
      pd = mem_data_o;
      if (done_o) begin n_done++; done_cyc = c; end
      if (misalign_o) begin n_mis++; mis_cyc = c; end
      if (done_o || misalign_o) break;
      @(negedge clk);
    end
    if (n_done + n_mis > 0) begin
      @(negedge clk);
      chk("pulse_end", done_o | misalign_o, 0);
      chk("ready_after", ready_o, 1);
    end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr, data;
    logic        mis;
    int          nb;
    logic [31:0] fa, la;
    logic [7:0]  fd, ld;
  } vec_t;
  vec_t vt[8];

  initial begin
    int writes;
    vt[0] = '{2'd0, 32'h100, 32'hDEADBEEF, 1'b0, 1, 32'h100, 32'h100, 8'hEF, 8'hEF};
    vt[1] = '{2'd2, 32'h200, 32'h11223344, 1'b0, 4, 32'h200, 32'h203, 8'h44, 8'h11};
    vt[2] = '{2'd1, 32'h306, 32'hCAFEBABE, 1'b0, 2, 32'h306, 32'h307, 8'hBE, 8'hBA};
    vt[3] = '{2'd0, 32'h3,   32'h12345678, 1'b0, 1, 32'h3,   32'h3,   8'h78, 8'h78};
    vt[4] = '{2'd1, 32'h101, 32'h0,        1'b1, 0, 32'h0,   32'h0,   8'h00, 8'h00};
    vt[5] = '{2'd2, 32'h102, 32'h0,        1'b1, 0, 32'h0,   32'h0,   8'h00, 8'h00};
    vt[6] = '{2'd3, 32'h0,   32'h0,        1'b1, 0, 32'h0,   32'h0,   8'h00, 8'h00};
    vt[7] = '{2'd2, 32'hFFFFFFFC, 32'h01020304, 1'b0, 4, 32'hFFFFFFFC, 32'hFFFFFFFF, 8'h04, 8'h01};
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_mis", misalign_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    foreach (vt[i]) begin
      run(vt[i].size, vt[i].addr, vt[i].data, 0);
      chk("vec_mis", n_mis, vt[i].mis);
      chk("vec_done", n_done, !vt[i].mis);
      chk("vec_nbytes", nx, vt[i].nb);
      if (vt[i].nb > 0) begin
        chk("vec_first_addr", xa[0], vt[i].fa);
        chk("vec_first_data", xd[0], vt[i].fd);
        chk("vec_last_addr", xa[vt[i].nb-1], vt[i].la);
        chk("vec_last_data", xd[vt[i].nb-1], vt[i].ld);
        chk("vec_done_cycle", done_cyc, vt[i].nb + 1);
      end else chk("vec_mis_cycle", mis_cyc, 1);
    end

    for (int k = 0; k < 40; k++) begin
      logic [1:0] s;
      logic [31:0] a, d;
      int nb;
      bit ok;
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 1);
      nb = s == 0 ? 1 : s == 1 ? 2 : 4;
      ok = s == 0 || (s == 1 && a % 2 == 0) || (s == 2 && a % 4 == 0);
      run(s, a, d, 1);
      chk("rnd_mis", n_mis, !ok);
      chk("rnd_done", n_done, ok);
      chk("rnd_nbytes", nx, ok ? nb : 0);
      if (ok && nx == nb)
        for (int i = 0; i < nb; i++) begin
          chk("rnd_addr", xa[i], a + i);
          chk("rnd_data", xd[i], (d / (32'd1 << (8 * i))) % 256);
        end
    end

    run(2'd1, 32'h302, 32'hAAAA5566, 2);
    chk("stall_nbytes", nx, 2);
    chk("stall_a0", xa[0], 32'h302);
    chk("stall_d0", xd[0], 8'h66);
    chk("stall_a1", xa[1], 32'h303);
    chk("stall_d1", xd[1], 8'h55);
    chk("stall_done_cycle", done_cyc, 6);

    @(negedge clk);
    req = 1; size = 2; addr = 32'h500; data = 32'h99887766; mem_ready = 1;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_addr", mem_addr_o, 32'h502);
    rst_n = 0;
    #1;
    chk("rst_mid_we", mem_we_o, 0);
    chk("rst_mid_maddr", mem_addr_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_ready", ready_o, 1);
    @(negedge clk);
    rst_n = 1;
    writes = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we_o) writes++;
    end
    chk("rst_residual_writes", writes, 0);
    chk("rst_release_ready", ready_o, 1);

    req = 1; size = 2; addr = 32'h600; data = 32'hA1B2C3D4; mem_ready = 1;
    @(negedge clk);
    size = 0; addr = 32'h700; data = 32'h0000005A;
    nx = 0; n_done = 0;
    for (int c = 0; c < 20 && !done_o; c++) begin
      if (mem_we_o && nx < 8) begin
        xa[nx] = mem_addr_o;
        xd[nx] = mem_data_o;
        nx++;
      end
      @(negedge clk);
    end
    chk("b2b_done", done_o, 1);
    chk("b2b_nbytes", nx, 4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_addr", xa[i], 32'h600 + i);
      chk("b2b_data", xd[i], (32'hA1B2C3D4 >> (8 * i)) & 32'hFF);
    end
    @(negedge clk);
    chk("b2b_idle_ready", ready_o, 1);
    @(negedge clk);
    req = 0;
    chk("b2b_second_we", mem_we_o, 1);
    chk("b2b_second_addr", mem_addr_o, 32'h700);
    chk("b2b_second_data", mem_data_o, 8'h5A);
    @(negedge clk);
    chk("b2b_second_done", done_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
Store-path counterpart of the load-side sign/zero extender in the Simple-MIPS datapath. It takes a 32-bit register value plus a store size (byte/half/word) and narrows it into a sequence of byte writes on a byte-wide data-memory port. It checks alignment, serialises the bytes under a memory ready handshake, and reports completion or misalignment to the pipeline control.

Parameters:
ADDR_W, 32, width of address input and memory address output
DATA_W, 32, width of store data input; fixed at 32, not intended to be overridden

Ports:
clk_i  input  1  single system clock, rising edge
rst_i  input  1  asynchronous, active-low reset
req_i  input  1  store request valid
ready_o  output  1  unit idle and able to accept req_i
size_i  input  2  0=byte, 1=halfword, 2=word, 3=illegal
addr_i  input  ADDR_W  store byte address
data_i  input  32  register value; low-order bytes are used for byte/half
mem_ready_i  input  1  memory accepts the current byte this cycle
mem_we_o  output  1  byte write strobe
mem_addr_o  output  ADDR_W  byte address of the current write
mem_data_o  output  8  byte being written
busy_o  output  1  high from accept until done/error completes
done_o  output  1  one-cycle pulse after the last byte is accepted
misalign_o  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; ready_o=1; all other outputs and internal regs=0. Reset mid-transfer aborts the transfer and issues no further writes.
- States: IDLE, WRITE, DONE, ERR.
- IDLE: ready_o=1, busy_o=0. Accept occurs when req_i=1 at a rising edge. Inputs are sampled only at accept; later changes are ignored.
- Alignment check at accept:
  - half needs addr_i[0]=0.
  - word needs addr_i[1:0]=0.
  - size_i=3 is always rejected.
  - Failure -> ERR. Success -> latch addr, data and last_idx (0/1/3), set idx=0, go to WRITE.
- ERR (1 cycle): misalign_o=1, busy_o=1, no mem_we_o, then IDLE. done_o is not asserted.
- WRITE:
  - mem_we_o=1, mem_addr_o=base+idx, mem_data_o=data[8*idx+7:8*idx]. Ordering is little-endian, lowest address first.
  - Handshake: a byte is transferred when mem_we_o=1 and mem_ready_i=1. If mem_ready_i=0, hold addr/data/we unchanged. No byte is dropped or duplicated.
  - On transfer with idx==last_idx -> DONE; otherwise idx+1.
- DONE (1 cycle): done_o=1, busy_o=1, mem_we_o=0, then IDLE.
- busy_o = (state != IDLE). ready_o = (state == IDLE).
- Latency with mem_ready_i tied high:
  - byte: accept at edge 0, write cycle 1, done cycle 2, ready again cycle 3.
  - word: writes cycles 1-4, done cycle 5.
- Back-to-back: a new request is accepted only in IDLE. A request held during busy is accepted on the first IDLE edge.
- Address arithmetic is mod 2^ADDR_W. Wrap cannot occur for aligned accesses.
- Outside WRITE: mem_addr_o and mem_data_o are 0.

Test Plan:
1. Reset, then byte store addr=0x100, data=0xDEADBEEF, mem_ready_i=1 -> a single write {0x100, 0xEF} in cycle 1; done_o pulses in cycle 2; no other writes.
2. Word store addr=0x200, data=0x11223344 -> writes {0x200,0x44}, {0x201,0x33}, {0x202,0x22}, {0x203,0x11} on consecutive cycles, then done_o.
3. Half store addr=0x302, data=0xAAAA5566, with mem_ready_i=0 for 3 cycles on the first byte -> {0x302,0x66} held stable 4 cycles, then {0x303,0x55}, then done_o; exactly 2 transfers.
4. Misaligned requests (half @0x101, word @0x102, size=3 @0x0) -> misalign_o pulses 1 cycle each; mem_we_o never rises; done_o stays 0.
5. Assert rst_i=0 after the 2nd byte of a word store -> outputs 0 immediately; after release ready_o=1 and no residual writes occur.
6. req_i held high across a word store, followed by a byte store -> the second request is accepted on the cycle after done_o; data/addr changes during busy have no effect on the first transfer.
